// File: rtl/tt_um_byte_fifo.sv
// ============================================================================
// Module      : tt_um_byte_fifo
// Description : 8-entry byte FIFO with synchronized edge-detected strobes,
//               show-ahead head output and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

   logic [2:0]      r_s1, r_s2, r_s3;
   logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [c_CW-1:0] r_count;
   logic            r_ovf, r_udf;
   logic [7:0]      r_mem [DEPTH];

   logic [2:0] w_pulse;
   logic       w_wr_p, w_rd_p, w_clr_p;
   logic       w_full, w_empty;
   logic       w_do_wr, w_do_rd;
   logic       w_set_ovf, w_set_udf;
   logic       w_unused;

   // Strobe pins: two-flop synchronizer plus history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 3'b000;
         r_s2 <= 3'b000;
         r_s3 <= 3'b000;
      end else begin
         r_s1 <= uio_in[2:0];
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_pulse = r_s2 & ~r_s3;
   assign w_wr_p  = w_pulse[0];
   assign w_rd_p  = w_pulse[1];
   assign w_clr_p = w_pulse[2];

   assign w_full  = (r_count == c_FULL);
   assign w_empty = (r_count == '0);

   // A read alongside a write frees the head slot, so a full FIFO still accepts
   assign w_do_rd   = w_rd_p && !w_empty;
   assign w_do_wr   = w_wr_p && (!w_full || w_rd_p);
   assign w_set_ovf = w_wr_p && w_full && !w_rd_p;
   assign w_set_udf = w_rd_p && w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
         r_ovf <= w_set_ovf | (r_ovf & ~w_clr_p);
         r_udf <= w_set_udf | (r_udf & ~w_clr_p);
      end
   end

   // Storage is intentionally left unreset
   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr_ptr] <= ui_in;
   end

   assign uo_out   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign uio_out  = {r_udf, r_ovf, w_empty, w_full, 4'b0000};
   assign uio_oe   = 8'hF0;

   assign w_unused = &{1'b0, ena, uio_in[7:3]};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_byte_fifo.sv
// ============================================================================
// Module      : tb_tt_um_byte_fifo
// Description : Self-checking bench for tt_um_byte_fifo (queue model + directed).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_byte_fifo;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks = 0;
   int n_err    = 0;

   tt_um_byte_fifo #(.DEPTH(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus sticky flags. A pin's action lands two
   // edges after it is first sampled high, provided it was sampled low just before.
   logic [7:0] q[$];
   logic       m_ovf, m_udf;
   logic [2:0] h1, h2, h3;

   always @(posedge clk or negedge rst_n) begin
      logic [2:0] act;
      if (!rst_n) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         h1 = 3'b0; h2 = 3'b0; h3 = 3'b0;
      end else begin
         act = h2 & ~h3;
         h3 = h2; h2 = h1; h1 = uio_in[2:0];
         if (act[2]) begin m_ovf = 1'b0; m_udf = 1'b0; end
         if (act[0] && act[1]) begin
            if (q.size() == 0) begin q.push_back(ui_in); m_udf = 1'b1; end
            else begin void'(q.pop_front()); q.push_back(ui_in); end
         end else if (act[0]) begin
            if (q.size() == 8) m_ovf = 1'b1;
            else q.push_back(ui_in);
         end else if (act[1]) begin
            if (q.size() == 0) m_udf = 1'b1;
            else void'(q.pop_front());
         end
      end
   end

   function automatic logic [7:0] exp_uo();
      return (q.size() == 0) ? 8'h00 : q[0];
   endfunction

   function automatic logic [7:0] exp_uio();
      return {m_udf, m_ovf, q.size() == 0, q.size() == 8, 4'b0000};
   endfunction

   always @(posedge clk) begin
      #1;
      check("model uo_out",  uo_out,  exp_uo());
      check("model uio_out", uio_out, exp_uio());
      check("model uio_oe",  uio_oe,  8'hF0);
   end

   // Single-edge strobe on the pins in mask; data held until the commit edge
   task automatic strobe(input logic [2:0] mask, input logic [7:0] data);
      @(negedge clk);
      ui_in  = data;
      uio_in = {5'b10101, mask};
      @(negedge clk);
      uio_in = 8'h00;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      repeat (2) @(negedge clk);
      check("reset uo_out",  uo_out,  8'h00);
      check("reset uio_out", uio_out, 8'h20);
      check("reset uio_oe",  uio_oe,  8'hF0);
      rst_n = 1'b1;

      // Single write
      strobe(3'b001, 8'hA5);
      check("write uo_out",  uo_out,  8'hA5);
      check("write uio_out", uio_out, 8'h00);
      strobe(3'b010, 8'h00);
      check("drain uio_out", uio_out, 8'h20);

      // Fill, overflow, drain in order
      for (int i = 1; i <= 8; i++) strobe(3'b001, 8'(i));
      check("full uio_out", uio_out, 8'h10);
      strobe(3'b001, 8'h09);
      check("ovf uio_out", uio_out, 8'h50);
      check("ovf uo_out",  uo_out,  8'h01);
      for (int i = 1; i <= 8; i++) begin
         check("read order", uo_out, 8'(i));
         strobe(3'b010, 8'h00);
      end
      check("drained uo_out",  uo_out,  8'h00);
      check("drained uio_out", uio_out, 8'h60);
      strobe(3'b100, 8'h00);
      check("clear ovf", uio_out, 8'h20);

      // Underflow and clear
      strobe(3'b010, 8'h00);
      check("udf uio_out", uio_out, 8'hA0);
      strobe(3'b100, 8'h00);
      check("clear udf", uio_out, 8'h20);

      // Full FIFO with simultaneous write+read, across pointer wrap
      for (int i = 0; i < 8; i++) strobe(3'b001, 8'(8'h10 + i));
      strobe(3'b011, 8'h18);
      check("full wr+rd uio_out", uio_out, 8'h10);
      check("full wr+rd uo_out",  uo_out,  8'h11);
      for (int i = 0; i < 8; i++) begin
         check("wrap read order", uo_out, 8'(8'h11 + i));
         strobe(3'b010, 8'h00);
      end
      check("wrap drained", uio_out, 8'h20);

      // Empty FIFO with simultaneous write+read
      strobe(3'b011, 8'h3C);
      check("empty wr+rd uo_out",  uo_out,  8'h3C);
      check("empty wr+rd uio_out", uio_out, 8'h80);
      strobe(3'b110, 8'h00);
      check("clear+read uio_out", uio_out, 8'h20);

      // Mid-stream reset with write strobe held through release
      strobe(3'b001, 8'h41);
      strobe(3'b001, 8'h42);
      strobe(3'b001, 8'h43);
      check("pre-reset uo_out", uo_out, 8'h41);
      @(negedge clk);
      ui_in  = 8'h77;
      uio_in = 8'h01;
      rst_n  = 1'b0;
      #1;
      check("mid reset uo_out",  uo_out,  8'h00);
      check("mid reset uio_out", uio_out, 8'h20);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      uio_in = 8'h00;
      repeat (3) @(negedge clk);
      check("held write uo_out",  uo_out,  8'h77);
      check("held write uio_out", uio_out, 8'h00);
      strobe(3'b010, 8'h00);
      check("single write only", uio_out, 8'h20);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire
